// File: rtl/cfg_pkg.sv
// Shared configuration-memory constants and the load-sequencer state encoding.
// MEM_DEPTH is the config-memory depth used by the loader and the sequencer.
package cfg_pkg;

    localparam int MEM_DEPTH = 512;

    localparam int SEQ_PREAMBLE_LEN      = 3;
    localparam int SEQ_PREAMBLE_WAIT_CYC = 30_000_000;
    localparam int SEQ_POWERUP_WAIT_CYC  = 1_000_000;
    localparam int SEQ_ENTRY_TIMEOUT_CYC = 200_000;
    localparam int SEQ_MAX_RETRY         = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_ISSUE,
        S_WAIT_DONE,
        S_PRE_WAIT,
        S_NEXT,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter shared by every wait and timeout in the sequencer.
// tc_o is high whenever the count has reached zero.
module seq_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt;

    // Load wins over clear so a wait can be armed from an idle state.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc_o = (cnt == '0);

endmodule

// File: rtl/si5340_cfg_sequencer.sv
// Walks the single-entry Si5340 config loader over every config-memory entry,
// with power-up wait, post-preamble settle, per-entry timeout and bounded retry.
module si5340_cfg_sequencer
    import cfg_pkg::*;
#(
    parameter int MEM_DEPTH         = cfg_pkg::MEM_DEPTH,
    parameter int IDX_W             = $clog2(MEM_DEPTH),
    parameter int PREAMBLE_LEN      = SEQ_PREAMBLE_LEN,
    parameter int PREAMBLE_WAIT_CYC = SEQ_PREAMBLE_WAIT_CYC,
    parameter int POWERUP_WAIT_CYC  = SEQ_POWERUP_WAIT_CYC,
    parameter int ENTRY_TIMEOUT_CYC = SEQ_ENTRY_TIMEOUT_CYC,
    parameter int MAX_RETRY         = SEQ_MAX_RETRY
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             load_o,
    output logic             write_o,
    output logic [IDX_W-1:0] idx_o,
    input  logic             entry_done_i,
    input  logic             entry_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IDX_W-1:0] err_idx_o,
    output logic [15:0]      retry_total_o,
    output seq_state_t       state_dbg_o
);

    localparam int TMR_MAX = max3(PREAMBLE_WAIT_CYC, POWERUP_WAIT_CYC, ENTRY_TIMEOUT_CYC);
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam int PWR_LOAD_I = (POWERUP_WAIT_CYC > 0) ? POWERUP_WAIT_CYC - 1 : 0;
    localparam int PRE_LOAD_I = (PREAMBLE_WAIT_CYC > 0) ? PREAMBLE_WAIT_CYC - 1 : 0;
    localparam int TO_LOAD_I  = (ENTRY_TIMEOUT_CYC > 0) ? ENTRY_TIMEOUT_CYC - 1 : 0;
    localparam int PRE_LAST_I = (PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0;

    localparam logic [TMR_W-1:0] PWR_LOAD = TMR_W'(PWR_LOAD_I);
    localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(PRE_LOAD_I);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TO_LOAD_I);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_LAST_I);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_DEPTH - 1);
    localparam bit               USE_PRE  = (PREAMBLE_LEN > 0) && (PREAMBLE_WAIT_CYC > 0);

    seq_state_t         state;
    logic               load_q;
    logic [IDX_W-1:0]   idx;
    logic [RETRY_W-1:0] retry;
    logic               done_q;
    logic               err_q;
    logic [IDX_W-1:0]   err_idx;
    logic [15:0]        retry_total;

    logic               tmr_clear;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_tc;
    logic               ok_done;
    logic               pre_last;

    assign ok_done  = entry_done_i && !entry_err_i;
    assign pre_last = USE_PRE && (idx == PRE_LAST);

    // Loader handshake: load_o is a one-cycle request for entry idx_o; the loader
    // answers with exactly one entry_done_i pulse (entry_err_i qualifies it), and no
    // new load is issued until that answer or the entry timeout has been seen.
    always_comb begin
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                tmr_clear = 1'b1;
                if (start_i && !abort_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = PWR_LOAD;
                end
            end
            S_ISSUE: begin
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
            end
            S_WAIT_DONE: begin
                if (abort_i && !entry_done_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end else if (!abort_i && ok_done && pre_last) begin
                    tmr_load = 1'b1;
                    tmr_val  = PRE_LOAD;
                end
            end
            default: ;
        endcase
    end

    seq_wait_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= S_IDLE;
            load_q      <= 1'b0;
            idx         <= '0;
            retry       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_idx     <= '0;
            retry_total <= '0;
        end else begin
            load_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i && !abort_i) begin
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        err_idx     <= '0;
                        retry_total <= '0;
                        idx         <= '0;
                        retry       <= '0;
                        if (POWERUP_WAIT_CYC == 0) begin
                            state  <= S_ISSUE;
                            load_q <= 1'b1;
                        end else begin
                            state <= S_PWR_WAIT;
                        end
                    end
                end
                S_PWR_WAIT: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (tmr_tc) begin
                        state  <= S_ISSUE;
                        load_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= abort_i ? S_IDLE : S_WAIT_DONE;
                end
                // A completion in the same cycle as the timeout counts as success.
                S_WAIT_DONE: begin
                    if (abort_i) begin
                        state <= entry_done_i ? S_IDLE : S_DRAIN;
                    end else if (ok_done) begin
                        state <= pre_last ? S_PRE_WAIT : S_NEXT;
                    end else if (entry_done_i || tmr_tc) begin
                        if (retry < RETRY_W'(MAX_RETRY)) begin
                            retry  <= retry + RETRY_W'(1);
                            state  <= S_ISSUE;
                            load_q <= 1'b1;
                            if (retry_total != 16'hFFFF) begin
                                retry_total <= retry_total + 16'd1;
                            end
                        end else begin
                            err_q   <= 1'b1;
                            err_idx <= idx;
                            state   <= S_ERROR;
                        end
                    end
                end
                S_PRE_WAIT: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (tmr_tc) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (idx == IDX_LAST) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        retry  <= '0;
                        state  <= S_ISSUE;
                        load_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (entry_done_i || tmr_tc) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // An abort in the issue cycle suppresses the strobe so no transaction starts.
    assign load_o        = load_q && !abort_i;
    assign busy_o        = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign write_o       = busy_o;
    assign idx_o         = idx;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_idx_o     = err_idx;
    assign retry_total_o = retry_total;
    assign state_dbg_o   = state;

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Directed bench for si5340_cfg_sequencer with a small loader model that
// answers each load after a programmable delay, with optional NACKs or silence.
module tb_si5340_cfg_sequencer;
    import cfg_pkg::*;

    localparam int TB_DEPTH = 8;
    localparam int TB_IDX_W = 3;

    logic                clk_i = 1'b0;
    logic                arst_i = 1'b1;
    logic                start_i = 1'b0;
    logic                abort_i = 1'b0;
    logic                entry_done_i = 1'b0;
    logic                entry_err_i = 1'b0;
    logic                load_o;
    logic                write_o;
    logic [TB_IDX_W-1:0] idx_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic [TB_IDX_W-1:0] err_idx_o;
    logic [15:0]         retry_total_o;
    seq_state_t          state_dbg_o;

    si5340_cfg_sequencer #(
        .MEM_DEPTH         (TB_DEPTH),
        .PREAMBLE_LEN      (3),
        .PREAMBLE_WAIT_CYC (20),
        .POWERUP_WAIT_CYC  (5),
        .ENTRY_TIMEOUT_CYC (50),
        .MAX_RETRY         (2)
    ) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .load_o        (load_o),
        .write_o       (write_o),
        .idx_o         (idx_o),
        .entry_done_i  (entry_done_i),
        .entry_err_i   (entry_err_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .err_idx_o     (err_idx_o),
        .retry_total_o (retry_total_o),
        .state_dbg_o   (state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    // ---------------- loader model ----------------
    int  ld_delay = 10;
    int  hang_idx = -1;
    int  nack_left [TB_DEPTH];
    bit  model_en = 1'b1;
    bit  man_done = 1'b0;
    bit  pend = 1'b0;
    int  cd = 0;
    bit  pend_err = 1'b0;
    int  ld_idx_q [$];
    int  ld_cyc_q [$];

    always @(negedge clk_i) begin
        entry_done_i = model_en ? 1'b0 : man_done;
        entry_err_i  = 1'b0;
        if (arst_i) begin
            pend = 1'b0;
        end else begin
            if (model_en && pend) begin
                cd--;
                if (cd == 0) begin
                    entry_done_i = 1'b1;
                    entry_err_i  = pend_err;
                    pend = 1'b0;
                end
            end
            if (load_o) begin
                ld_idx_q.push_back(int'(idx_o));
                ld_cyc_q.push_back(cyc);
                if (model_en && int'(idx_o) != hang_idx) begin
                    pend     = 1'b1;
                    cd       = ld_delay;
                    pend_err = (nack_left[idx_o] > 0);
                    if (pend_err) nack_left[idx_o]--;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    int st_cyc = 0;

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_log();
        ld_idx_q.delete();
        ld_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        st_cyc  = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy_o, 1'b0);
    endtask

    task automatic wait_loads(input string tag, input int cnt, input int budget);
        int n = 0;
        while (ld_idx_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        check(tag, ld_idx_q.size() >= cnt, 1'b1);
    endtask

    task automatic wait_state(input string tag, input seq_state_t st, input int budget);
        int n = 0;
        while (state_dbg_o != st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state_dbg_o), 32'(st));
    endtask

    function automatic int count_idx(input int v);
        int n = 0;
        foreach (ld_idx_q[i]) if (ld_idx_q[i] == v) n++;
        return n;
    endfunction

    // ---------------- directed sequence ----------------
    int c;

    initial begin
        foreach (nack_left[i]) nack_left[i] = 0;
        repeat (3) tick();
        arst_i = 1'b0;
        tick();

        check("rst_load", load_o, 1'b0);
        check("rst_write", write_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_idx", idx_o, 0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_err_idx", err_idx_o, 0);
        check("rst_retry_total", retry_total_o, 0);
        check("rst_state", 32'(state_dbg_o), 32'(S_IDLE));

        // Clean run: 10-cycle loader, no errors.
        clear_log();
        pulse_start();
        check("t1_write_busy", write_o, 1'b1);
        wait_idle("t1_idle", 400);
        check("t1_nloads", ld_idx_q.size(), 8);
        for (int i = 0; i < TB_DEPTH; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < TB_DEPTH; i++) check("t1_load_idx", ld_idx_q[i], exp_q.pop_front());
        check("t1_pwr_wait", ld_cyc_q[0] - (st_cyc + 1), 5);
        check("t1_pre_gap_ge20", (ld_cyc_q[3] - (ld_cyc_q[2] + 10)) >= 20, 1'b1);
        check("t1_pre_gap", ld_cyc_q[3] - (ld_cyc_q[2] + 10), 22);
        check("t1_entry_spacing", ld_cyc_q[5] - ld_cyc_q[4], 12);
        check("t1_done", done_o, 1'b1);
        check("t1_err", err_o, 1'b0);
        check("t1_retry_total", retry_total_o, 0);
        check("t1_idx_hold", idx_o, 7);
        check("t1_write_idle", write_o, 1'b0);

        // NACK on the first two attempts of entry 4.
        nack_left[4] = 2;
        clear_log();
        pulse_start();
        check("t2_done_cleared", done_o, 1'b0);
        wait_idle("t2_idle", 500);
        check("t2_loads_idx4", count_idx(4), 3);
        check("t2_nloads", ld_idx_q.size(), 10);
        check("t2_retry_total", retry_total_o, 2);
        check("t2_done", done_o, 1'b1);
        check("t2_err", err_o, 1'b0);

        // Entry 5 never answers: three attempts, each ending in a 50-cycle timeout.
        hang_idx = 5;
        clear_log();
        pulse_start();
        wait_idle("t3_idle", 800);
        check("t3_loads_idx5", count_idx(5), 3);
        check("t3_nloads", ld_idx_q.size(), 8);
        check("t3_retry_gap_a", ld_cyc_q[6] - ld_cyc_q[5], 51);
        check("t3_retry_gap_b", ld_cyc_q[7] - ld_cyc_q[6], 51);
        check("t3_err_timing", cyc - ld_cyc_q[7], 51);
        check("t3_err", err_o, 1'b1);
        check("t3_err_idx", err_idx_o, 5);
        check("t3_done", done_o, 1'b0);
        check("t3_retry_total", retry_total_o, 2);
        check("t3_state", 32'(state_dbg_o), 32'(S_ERROR));

        // Abort while entry 2 is in flight; loader answers 30 cycles after its load.
        hang_idx = -1;
        ld_delay = 30;
        clear_log();
        pulse_start();
        check("t4_err_cleared", err_o, 1'b0);
        check("t4_err_idx_cleared", err_idx_o, 0);
        wait_loads("t4_load2_seen", 3, 300);
        c = ld_cyc_q[2];
        repeat (5) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_state_drain", 32'(state_dbg_o), 32'(S_DRAIN));
        check("t4_busy_drain", busy_o, 1'b1);
        wait_idle("t4_idle", 100);
        check("t4_drain_len", cyc - c, 31);
        repeat (60) tick();
        check("t4_no_more_loads", ld_idx_q.size(), 3);
        check("t4_state", 32'(state_dbg_o), 32'(S_IDLE));
        check("t4_done", done_o, 1'b0);
        check("t4_err", err_o, 1'b0);

        // start_i while busy is ignored.
        ld_delay = 10;
        clear_log();
        pulse_start();
        wait_loads("t5_load1_seen", 2, 100);
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t5_start_busy_state", 32'(state_dbg_o), 32'(S_WAIT_DONE));
        check("t5_start_busy_idx", idx_o, 1);
        wait_idle("t5_idle", 400);
        check("t5_nloads", ld_idx_q.size(), 8);
        check("t5_done", done_o, 1'b1);

        // Abort from PWR_WAIT goes straight to IDLE; then start+abort together.
        clear_log();
        pulse_start();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t5_abort_pwr_state", 32'(state_dbg_o), 32'(S_IDLE));
        check("t5_abort_pwr_done", done_o, 1'b0);
        check("t5_abort_pwr_loads", ld_idx_q.size(), 0);
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        tick();
        check("t5_start_abort_state", 32'(state_dbg_o), 32'(S_IDLE));
        check("t5_start_abort_busy", busy_o, 1'b0);

        // Spurious entry_done_i in IDLE.
        model_en = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        tick();
        model_en = 1'b1;
        check("t5_spurious_state", 32'(state_dbg_o), 32'(S_IDLE));
        check("t5_spurious_done", done_o, 1'b0);
        check("t5_spurious_err", err_o, 1'b0);
        check("t5_spurious_retry", retry_total_o, 0);

        // Loader answers in the same cycle the entry timeout expires.
        ld_delay = 50;
        clear_log();
        pulse_start();
        wait_idle("t5_sim_idle", 1000);
        check("t5_sim_nloads", ld_idx_q.size(), 8);
        check("t5_sim_retry_total", retry_total_o, 0);
        check("t5_sim_done", done_o, 1'b1);
        check("t5_sim_err", err_o, 1'b0);

        // Asynchronous reset during the preamble settle wait.
        ld_delay = 10;
        clear_log();
        pulse_start();
        wait_state("t6_pre_wait_seen", S_PRE_WAIT, 200);
        repeat (3) tick();
        check("t6_pre_idx", idx_o, 2);
        check("t6_pre_busy", busy_o, 1'b1);
        #2;
        arst_i = 1'b1;
        #1;
        check("t6_rst_busy", busy_o, 1'b0);
        check("t6_rst_write", write_o, 1'b0);
        check("t6_rst_idx", idx_o, 0);
        check("t6_rst_state", 32'(state_dbg_o), 32'(S_IDLE));
        check("t6_rst_load", load_o, 1'b0);
        check("t6_rst_done", done_o, 1'b0);
        tick();
        arst_i = 1'b0;
        tick();
        clear_log();
        pulse_start();
        wait_idle("t6_idle", 400);
        check("t6_first_idx", ld_idx_q[0], 0);
        check("t6_nloads", ld_idx_q.size(), 8);
        check("t6_done", done_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/si5340_cfg_sequencer.md
Name: si5340_cfg_sequencer

Overview:
- Top-level sequencer for Si5340 configuration loading.
- Steps the single-entry config loader through every config-memory entry:
  - optional power-up wait;
  - enforced settle delay after the preamble entries;
  - per-entry timeout with bounded retry;
  - sticky done/error reporting.
- Sits between system control (start/abort) and the loader's load/write/index interface; owns the config-memory index.

Parameters:
- MEM_DEPTH, 512, number of config entries (from cfg_pkg).
- IDX_W, $clog2(MEM_DEPTH), index width.
- PREAMBLE_LEN, 3, entries 0..PREAMBLE_LEN-1 form the preamble; 0 disables the settle wait.
- PREAMBLE_WAIT_CYC, 30_000_000, settle cycles after the last preamble entry (300 ms at 100 MHz).
- POWERUP_WAIT_CYC, 1_000_000, cycles waited after start before the first entry; 0 skips the wait.
- ENTRY_TIMEOUT_CYC, 200_000, cycles allowed per entry attempt.
- MAX_RETRY, 3, retries per entry after the first attempt.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  start pulse; honoured only in IDLE, DONE or ERROR.
- abort_i  in  1  abort request; priority over start_i.
- load_o  out  1  one-cycle load strobe to the loader.
- write_o  out  1  loader mode; always 1 (write) while busy.
- idx_o  out  IDX_W  config-memory index the loader uses for the current entry.
- entry_done_i  in  1  one-cycle pulse from the loader when the entry transaction ends.
- entry_err_i  in  1  qualifies entry_done_i; 1 = NACK seen during the entry.
- busy_o  out  1  high in every state except IDLE, DONE and ERROR.
- done_o  out  1  sticky; all entries written.
- err_o  out  1  sticky; retries exhausted.
- err_idx_o  out  IDX_W  index of the failing entry; valid while err_o=1.
- retry_total_o  out  16  saturating count of retries in the current run.

Behaviour:
- Reset (arst_i=1, async) forces:
  - state IDLE;
  - all outputs 0;
  - all counters 0.
- Single shared wait/timeout counter; width $clog2 of max(PREAMBLE_WAIT_CYC, POWERUP_WAIT_CYC, ENTRY_TIMEOUT_CYC)+1.
- States: IDLE, PWR_WAIT, ISSUE, WAIT_DONE, PRE_WAIT, NEXT, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + start_i (abort_i=0):
  - clear done_o, err_o, err_idx_o, retry_total_o;
  - idx_o=0, retry=0;
  - go PWR_WAIT, or ISSUE if POWERUP_WAIT_CYC=0.
- PWR_WAIT: count to POWERUP_WAIT_CYC-1, then ISSUE.
- ISSUE:
  - load_o=1 for exactly this cycle;
  - timer cleared;
  - next state WAIT_DONE.
  - Load-to-load spacing is therefore at least 2 cycles.
- WAIT_DONE, on entry_done_i=1 with entry_err_i=0:
  - if idx_o == PREAMBLE_LEN-1 and PREAMBLE_WAIT_CYC>0, go PRE_WAIT;
  - otherwise go NEXT.
- WAIT_DONE, on a failure (entry_done_i with entry_err_i=1, or timer == ENTRY_TIMEOUT_CYC-1 without done):
  - retry < MAX_RETRY: retry++, retry_total_o++ (saturates at 0xFFFF), go ISSUE with idx_o unchanged;
  - otherwise: err_o=1, err_idx_o=idx_o, go ERROR.
  - entry_done_i in the same cycle as the timeout counts as done (done wins).
- PRE_WAIT: count to PREAMBLE_WAIT_CYC-1, then NEXT.
- NEXT:
  - idx_o == MEM_DEPTH-1: done_o=1, go DONE (no wrap);
  - otherwise: idx_o++, retry=0, go ISSUE.
- abort_i:
  - from WAIT_DONE: go DRAIN, with load_o held 0;
  - from any other busy state: go IDLE next cycle, with load_o 0 that cycle.
  - done_o and err_o stay 0.
- DRAIN: wait for entry_done_i, or timer == ENTRY_TIMEOUT_CYC-1, then IDLE.
  - Never abandons an in-flight loader transaction.
- Ignored events:
  - entry_done_i outside WAIT_DONE/DRAIN;
  - start_i while busy_o=1.
- Reset mid-run returns immediately to the reset values; no loader handshake is honoured.
- write_o=1 while busy_o=1, else 0.
- idx_o holds its last value in DONE/ERROR for debug.

Decomposition:
- cfg_pkg gains:
  - seq_state_t enum;
  - SEQ_PREAMBLE_LEN, SEQ_PREAMBLE_WAIT_CYC, SEQ_POWERUP_WAIT_CYC, SEQ_ENTRY_TIMEOUT_CYC, SEQ_MAX_RETRY defaults;
  - existing MEM_DEPTH reused.
- One sub-module: seq_wait_timer.
  - Loadable down-counter with clear and terminal-count flag.
  - Shared by PWR_WAIT, PRE_WAIT, WAIT_DONE and DRAIN.
- FSM, index and retry logic stay in the top.

Test Plan (MEM_DEPTH=8, PREAMBLE_LEN=3, PREAMBLE_WAIT_CYC=20, POWERUP_WAIT_CYC=5, ENTRY_TIMEOUT_CYC=50, MAX_RETRY=2):
- Clean run: start_i; loader model returns done 10 cycles after each load, no errors. Required:
  - 8 load_o pulses with idx_o 0..7;
  - first load 5 cycles after PWR_WAIT entry;
  - gap from done(idx 2) to load(idx 3) ≥ 20 cycles;
  - done_o=1, busy_o=0, retry_total_o=0.
- NACK retry: entry_err_i=1 on the first two attempts of idx 4, then success. Required:
  - 3 loads at idx_o=4;
  - retry_total_o=2;
  - done_o=1, err_o=0.
- Exhausted retries: idx 5 never completes. Required:
  - 3 loads at idx 5, each followed by a 50-cycle timeout;
  - then err_o=1, err_idx_o=5, done_o=0, busy_o=0.
- Abort mid-entry: abort_i during WAIT_DONE of idx 2, with loader done 30 cycles later. Required:
  - no further load_o;
  - busy_o stays high until done;
  - then IDLE with done_o=0, err_o=0.
- Ignored and simultaneous events:
  - start_i while busy: no change;
  - start_i and abort_i together from IDLE: stays IDLE;
  - entry_done_i and timeout in the same cycle: treated as success;
  - spurious entry_done_i in IDLE: no change.
- Async reset mid-PRE_WAIT: arst_i asserted between clock edges clears all outputs immediately. After release, a new start_i restarts from idx_o=0.
